// File: rtl/calc_pkg.sv
// calc_pkg - shared constants, display codes and segment decode for the result display path.
// Rev 1.0
`default_nettype none

package calc_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DATA_W     = 16;
  localparam int BCD_W      = 20;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef logic [3:0] digit_code_t;
  localparam digit_code_t CODE_MINUS = 4'hA;
  localparam digit_code_t CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } disp_state_t;

  function automatic logic [6:0] seg_of(input digit_code_t code);
    logic [6:0] s;
    s = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (code == 4'(i)) s = SEG_DIGIT[i];
    end
    if (code == CODE_MINUS) s = SEG_MINUS;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_driver_if.sv
// disp_driver_if - result/completion input and seven-segment scan outputs of the display driver.
// Rev 1.0
`default_nettype none

interface disp_driver_if;
  import calc_pkg::*;

  logic [DATA_W-1:0]     value_in;
  logic                  load;
  logic                  busy;
  logic [6:0]            seg_out;
  logic [NUM_DIGITS-1:0] an_out;

  modport master (
    output value_in, load,
    input  busy, seg_out, an_out
  );

  modport slave (
    input  value_in, load,
    output busy, seg_out, an_out
  );

endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq - sequential double-dabble, one add-3/shift step per cycle, 16 steps per conversion.
// Rev 1.0
`default_nettype none

module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W:0]   mag,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  logic [DATA_W-1:0] mag_sr;
  logic [3:0]        iter;
  logic [BCD_W-1:0]  bcd_adj;

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // High during the final step, so the caller can commit on the very next edge.
  assign done = busy && (iter == 4'd0);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      busy   <= 1'b0;
      iter   <= 4'd0;
      mag_sr <= '0;
      bcd    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      iter   <= 4'd15;
      mag_sr <= mag[DATA_W-1:0];
      // Bit 16 enters as the already-shifted first bit; no add-3 can precede it.
      bcd    <= {{(BCD_W-1){1'b0}}, mag[DATA_W]};
    end else if (busy) begin
      {bcd, mag_sr} <= {bcd_adj, mag_sr} << 1;
      iter          <= iter - 4'd1;
      if (iter == 4'd0) busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/disp_driver.sv
// disp_driver - signed result to sign + 5 BCD digits with zero suppression, scanned onto 6 common-anode digits.
// Rev 1.0
`default_nettype none

module disp_driver
  import calc_pkg::*;
#(
  parameter int REFRESH_TICKS = 1000,
  parameter int CNT_W         = 16
)
(
  input  logic        clk,
  input  logic        RST,
  disp_driver_if.slave bus
);

  disp_state_t       state, next_state;
  logic              start;
  logic              conv_busy;
  logic              conv_done;
  logic              sign;
  logic              lead;
  logic [BCD_W-1:0]  bcd;
  logic [DATA_W:0]   mag;
  digit_code_t       disp      [NUM_DIGITS];
  digit_code_t       disp_next [NUM_DIGITS];
  logic [CNT_W-1:0]  presc;
  logic [2:0]        scan_idx;

  // 17-bit negate so that -32768 yields +32768.
  assign mag = bus.value_in[DATA_W-1] ? -{1'b1, bus.value_in} : {1'b0, bus.value_in};

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .RST   (RST),
    .start (start),
    .mag   (mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load && !conv_busy) begin
          start      = 1'b1;
          next_state = CONV;
        end
      end
      CONV:    if (conv_done) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Walk from the most significant magnitude digit down; blank until the first nonzero.
  always_comb begin
    lead = 1'b1;
    for (int d = NUM_DIGITS - 2; d >= 0; d--) begin
      if ((bcd[4*d +: 4] != 4'd0) || (d == 0)) lead = 1'b0;
      disp_next[d] = lead ? CODE_BLANK : bcd[4*d +: 4];
    end
    disp_next[NUM_DIGITS-1] = sign ? CODE_MINUS : CODE_BLANK;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      sign     <= 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++) disp[d] <= CODE_BLANK;
    end else begin
      state    <= next_state;
      bus.busy <= (next_state != IDLE);
      if (start) sign <= bus.value_in[DATA_W-1];
      if (state == COMMIT) begin
        for (int d = 0; d < NUM_DIGITS; d++) disp[d] <= disp_next[d];
      end
    end
  end

  // an_out and seg_out both derive from scan_idx in the same edge, so they never disagree.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      presc       <= '0;
      scan_idx    <= 3'd0;
      bus.an_out  <= ~NUM_DIGITS'(1);
      bus.seg_out <= SEG_BLANK;
    end else begin
      if (presc == CNT_W'(REFRESH_TICKS - 1)) begin
        presc    <= '0;
        scan_idx <= (scan_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      bus.an_out  <= ~(NUM_DIGITS'(1) << scan_idx);
      bus.seg_out <= seg_of(disp[scan_idx]);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_disp_driver.sv
// tb_disp_driver - directed vectors for disp_driver with hand-computed segment patterns.
// Rev 1.0
`default_nettype none

module tb_disp_driver;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  disp_driver_if bus ();

  disp_driver #(
    .REFRESH_TICKS (4),
    .CNT_W         (4)
  ) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Collect the segment pattern shown while each digit is enabled; digit k lands in segs[7k +: 7].
  task automatic read_digits(output logic [41:0] segs);
    logic [5:0] seen;
    logic [5:0] pat;
    seen = '0;
    segs = '1;
    for (int c = 0; c < 60 && seen != 6'h3F; c++) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
        pat = ~(6'b1 << k);
        if (bus.an_out == pat) begin
          segs[7*k +: 7] = bus.seg_out;
          seen[k]        = 1'b1;
        end
      end
    end
    check("scan_cover", seen, 6'h3F);
  endtask

  // Called at a negedge; the following posedge samples load.
  task automatic run_load(input string tag, input logic [15:0] v, input bit inject,
                          input logic [41:0] exp);
    int          cnt;
    logic [41:0] got;
    bus.value_in = v;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      if (inject && cnt == 5) begin
        bus.value_in = 16'd77;
        bus.load     = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    check({tag, "_busy_len"}, cnt, 17);
    read_digits(got);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s_d%0d", tag, k), got[7*k +: 7], exp[7*k +: 7]);
  endtask

  initial begin
    logic [41:0] segs;
    logic [5:0]  prev;
    logic [5:0]  exp_an;
    int          hold;
    int          idx;

    bus.value_in = '0;
    bus.load     = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_seg", bus.seg_out, 7'h7F);
    check("rst_an", bus.an_out, 6'b111110);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Scan order and dwell time with REFRESH_TICKS=4.
    prev = bus.an_out;
    hold = 0;
    while (bus.an_out == prev && hold < 10) begin
      @(negedge clk);
      hold++;
    end
    idx = -1;
    for (int k = 0; k < 6; k++) begin
      exp_an = ~(6'b1 << k);
      if (bus.an_out == exp_an) idx = k;
    end
    check("scan_first", idx, 1);
    for (int s = 0; s < 7; s++) begin
      exp_an = ~(6'b1 << idx);
      check("scan_an", bus.an_out, exp_an);
      prev = bus.an_out;
      hold = 0;
      while (bus.an_out == prev && hold < 10) begin
        @(negedge clk);
        hold++;
      end
      check("scan_hold", hold, 4);
      idx = (idx + 1) % 6;
    end

    read_digits(segs);
    check("blank_all", segs, {6{7'h7F}});

    run_load("pos46", 16'd46,   1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h02});
    run_load("neg24", 16'hFFE8, 1'b0, {7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h19});
    run_load("min",   16'h8000, 1'b0, {7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00});
    run_load("max",   16'h7FFF, 1'b0, {7'h7F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h78});
    run_load("zero",  16'd0,    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

    // Reset in the middle of a conversion, then reload on the first edge after release.
    bus.value_in = 16'd999;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_seg", bus.seg_out, 7'h7F);
    check("mid_rst_an", bus.an_out, 6'b111110);
    @(negedge clk);
    rst = 1'b0;
    run_load("reload5", 16'd5, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
